// File: rtl/titan_pkg.sv
// Shared trap-controller definitions: cause codes, FSM/event encodings, trap bundle, redirect target helper.
package titan_pkg;

  localparam logic [3:0] CAUSE_MEI          = 4'd11;
  localparam logic [3:0] CAUSE_MSI          = 4'd3;
  localparam logic [3:0] CAUSE_MTI          = 4'd7;
  localparam logic [3:0] CAUSE_ILLEGAL_INST = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT   = 4'd3;
  localparam logic [3:0] CAUSE_MCALL        = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_TRAP,
    ST_XRET,
    ST_REDIRECT
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_EXC,
    EV_IRQ,
    EV_MRET
  } event_t;

  typedef struct packed {
    logic mei;
    logic msi;
    logic mti;
  } irq_t;

  typedef struct packed {
    logic [3:0]  cause;
    logic        irq;
    logic [31:0] pc;
    logic [31:0] inst;
  } trap_t;

  function automatic logic [31:0] redirect_target(input event_t ev, input logic [3:0] cause,
                                                  input logic [31:0] mtvec, input logic [31:0] mepc,
                                                  input logic vec_en);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (ev == EV_MRET)
      return {mepc[31:2], 2'b00};
    if (ev == EV_IRQ && vec_en && mtvec[1:0] == 2'b01)
      return base + {26'd0, cause, 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/titan_irq_prio.sv
// Machine interrupt priority encoder (MEI > MSI > MTI), gated by mstatus.MIE.
// Purely combinational, zero latency; no flow control.
module titan_irq_prio
  import titan_pkg::*;
(
  input  irq_t       pending,
  input  irq_t       enable,
  input  logic       mstatus_mie,
  output logic       valid,
  output logic [3:0] cause
);

  irq_t active;
  assign active = pending & enable;

  always_comb begin
    valid = mstatus_mie & (active.mei | active.msi | active.mti);
    cause = 4'd0;
    if (active.mei)      cause = CAUSE_MEI;
    else if (active.msi) cause = CAUSE_MSI;
    else if (active.mti) cause = CAUSE_MTI;
  end

endmodule

// File: rtl/titan_trap_ctrl.sv
// Trap/MRET sequencer: flush on accept, drain, commit to CSRs, then redirect fetch.
// Latency accept->trap commit >= 2 cycles (drain-dependent); redirect held until redirect_ready_i.
module titan_trap_ctrl
  import titan_pkg::*;
#(
  parameter int VECTORED_EN = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        xint_meip_i,
  input  logic        xint_mtip_i,
  input  logic        xint_msip_i,
  input  logic        mie_meie_i,
  input  logic        mie_mtie_i,
  input  logic        mie_msie_i,
  input  logic        mstatus_mie_i,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_inst_i,
  input  logic        mret_i,
  input  logic [31:0] commit_pc_i,
  input  logic        pipe_empty_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic        redirect_ready_i,
  output logic        trap_valid_o,
  output logic [3:0]  exception_code_o,
  output logic        interrupt_code_o,
  output logic [31:0] exception_pc_o,
  output logic [31:0] exception_inst_o,
  output logic        inst_xret_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  localparam logic VEC_EN = (VECTORED_EN != 0);

  irq_t        irq_pend;
  irq_t        irq_en;
  logic        irq_vld;
  logic [3:0]  irq_cause;

  state_t      state_q;
  event_t      ev_q;
  trap_t       trap_q;
  logic        stall_q;
  logic        trap_vld_q;
  logic        xret_q;
  logic        redir_vld_q;
  logic        redir_first_q;
  logic [31:0] redir_pc_q;
  logic [31:0] target_now;
  logic        idle;

  assign irq_pend = '{mei: xint_meip_i, msi: xint_msip_i, mti: xint_mtip_i};
  assign irq_en   = '{mei: mie_meie_i,  msi: mie_msie_i,  mti: mie_mtie_i};

  titan_irq_prio u_irq_prio (
    .pending     (irq_pend),
    .enable      (irq_en),
    .mstatus_mie (mstatus_mie_i),
    .valid       (irq_vld),
    .cause       (irq_cause)
  );

  assign idle       = (state_q == ST_IDLE);
  // Flush is asserted in the very cycle an event is accepted, so it cannot wait for a register.
  assign flush_o    = idle & ~rst_i & (exc_valid_i | mret_i | irq_vld);
  assign target_now = redirect_target(ev_q, trap_q.cause, mtvec_i, mepc_i, VEC_EN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      ev_q          <= EV_NONE;
      trap_q        <= '0;
      stall_q       <= 1'b0;
      trap_vld_q    <= 1'b0;
      xret_q        <= 1'b0;
      redir_vld_q   <= 1'b0;
      redir_first_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (exc_valid_i) begin
            ev_q    <= EV_EXC;
            trap_q  <= '{cause: exc_code_i, irq: 1'b0, pc: exc_pc_i, inst: exc_inst_i};
            state_q <= ST_DRAIN;
            stall_q <= 1'b1;
          end else if (mret_i) begin
            ev_q    <= EV_MRET;
            trap_q  <= '0;
            state_q <= ST_DRAIN;
            stall_q <= 1'b1;
          end else if (irq_vld) begin
            ev_q    <= EV_IRQ;
            trap_q  <= '{cause: irq_cause, irq: 1'b1, pc: commit_pc_i, inst: 32'd0};
            state_q <= ST_DRAIN;
            stall_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (pipe_empty_i) begin
            if (ev_q == EV_MRET) begin
              state_q <= ST_XRET;
              xret_q  <= 1'b1;
            end else begin
              state_q    <= ST_TRAP;
              trap_vld_q <= 1'b1;
            end
          end
        end
        ST_TRAP, ST_XRET: begin
          trap_vld_q    <= 1'b0;
          xret_q        <= 1'b0;
          state_q       <= ST_REDIRECT;
          redir_vld_q   <= 1'b1;
          redir_first_q <= 1'b1;
        end
        ST_REDIRECT: begin
          // CSRs have settled after the commit cycle; freeze the target on the first redirect cycle.
          redir_first_q <= 1'b0;
          if (redir_first_q)
            redir_pc_q <= target_now;
          if (redirect_ready_i) begin
            state_q     <= ST_IDLE;
            redir_vld_q <= 1'b0;
            stall_q     <= 1'b0;
            ev_q        <= EV_NONE;
            trap_q      <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign stall_o          = stall_q;
  assign trap_valid_o     = trap_vld_q;
  assign inst_xret_o      = xret_q;
  assign exception_code_o = trap_vld_q ? trap_q.cause : 4'd0;
  assign interrupt_code_o = trap_vld_q & trap_q.irq;
  assign exception_pc_o   = trap_vld_q ? trap_q.pc : 32'd0;
  assign exception_inst_o = trap_vld_q ? trap_q.inst : 32'd0;
  assign redirect_valid_o = redir_vld_q;
  assign redirect_pc_o    = !redir_vld_q ? 32'd0 : (redir_first_q ? target_now : redir_pc_q);

endmodule

// File: tb/tb_titan_trap_ctrl.sv
// Directed bench for titan_trap_ctrl: exceptions, interrupts, MRET, redirect stall, reset abort.
module tb_titan_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        xint_meip_i = 1'b0, xint_mtip_i = 1'b0, xint_msip_i = 1'b0;
  logic        mie_meie_i = 1'b0, mie_mtie_i = 1'b0, mie_msie_i = 1'b0, mstatus_mie_i = 1'b0;
  logic        exc_valid_i = 1'b0;
  logic [3:0]  exc_code_i = 4'd0;
  logic [31:0] exc_pc_i = 32'd0, exc_inst_i = 32'd0;
  logic        mret_i = 1'b0;
  logic [31:0] commit_pc_i = 32'd0;
  logic        pipe_empty_i = 1'b0;
  logic [31:0] mtvec_i = 32'd0, mepc_i = 32'd0;
  logic        redirect_ready_i = 1'b0;
  logic        trap_valid_o;
  logic [3:0]  exception_code_o;
  logic        interrupt_code_o;
  logic [31:0] exception_pc_o, exception_inst_o;
  logic        inst_xret_o, flush_o, stall_o, redirect_valid_o;
  logic [31:0] redirect_pc_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  titan_trap_ctrl #(.VECTORED_EN(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .xint_meip_i(xint_meip_i), .xint_mtip_i(xint_mtip_i), .xint_msip_i(xint_msip_i),
    .mie_meie_i(mie_meie_i), .mie_mtie_i(mie_mtie_i), .mie_msie_i(mie_msie_i),
    .mstatus_mie_i(mstatus_mie_i),
    .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i), .exc_inst_i(exc_inst_i),
    .mret_i(mret_i), .commit_pc_i(commit_pc_i), .pipe_empty_i(pipe_empty_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .redirect_ready_i(redirect_ready_i),
    .trap_valid_o(trap_valid_o), .exception_code_o(exception_code_o),
    .interrupt_code_o(interrupt_code_o), .exception_pc_o(exception_pc_o),
    .exception_inst_o(exception_inst_o), .inst_xret_o(inst_xret_o),
    .flush_o(flush_o), .stall_o(stall_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk(tag, {26'd0, flush_o, stall_o, trap_valid_o, inst_xret_o, redirect_valid_o, interrupt_code_o}, 32'd0);
    chk({tag, "_rpc"}, redirect_pc_o, 32'd0);
    chk({tag, "_bundle"}, exception_pc_o | exception_inst_o | {28'd0, exception_code_o}, 32'd0);
  endtask

  task automatic chk_trap(input string tag, input logic [3:0] code, input logic irq,
                          input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, "_vld"}, {31'd0, trap_valid_o}, 32'd1);
    chk({tag, "_code"}, {28'd0, exception_code_o}, {28'd0, code});
    chk({tag, "_int"}, {31'd0, interrupt_code_o}, {31'd0, irq});
    chk({tag, "_pc"}, exception_pc_o, pc);
    chk({tag, "_inst"}, exception_inst_o, inst);
  endtask

  initial begin
    // Reset
    cyc(); cyc();
    rst_i = 1'b0;
    #1;
    all_zero("reset");

    // Illegal-instruction exception, pipe already empty
    mtvec_i = 32'h0000_1000;
    exc_valid_i = 1'b1; exc_code_i = 4'd2; exc_pc_i = 32'h100; exc_inst_i = 32'hFFFF_FFFF;
    pipe_empty_i = 1'b1;
    #1;
    chk("exc_flush", {31'd0, flush_o}, 32'd1);
    chk("exc_stall_idle", {31'd0, stall_o}, 32'd0);
    cyc(); exc_valid_i = 1'b0; #1;
    chk("exc_drain_flush", {31'd0, flush_o}, 32'd0);
    chk("exc_drain_stall", {31'd0, stall_o}, 32'd1);
    chk("exc_drain_trap", {31'd0, trap_valid_o}, 32'd0);
    cyc();
    chk_trap("exc_trap", 4'd2, 1'b0, 32'h100, 32'hFFFF_FFFF);
    cyc(); redirect_ready_i = 1'b1; #1;
    chk("exc_trap_once", {31'd0, trap_valid_o}, 32'd0);
    chk("exc_rvld", {31'd0, redirect_valid_o}, 32'd1);
    chk("exc_rpc", redirect_pc_o, 32'h0000_1000);
    cyc(); redirect_ready_i = 1'b0; #1;
    all_zero("exc_back_idle");

    // Timer interrupt, vectored mtvec, interrupt drops after capture
    mtvec_i = 32'h0000_1001; mstatus_mie_i = 1'b1; mie_mtie_i = 1'b1; xint_mtip_i = 1'b1;
    commit_pc_i = 32'h200;
    #1;
    chk("mti_flush", {31'd0, flush_o}, 32'd1);
    cyc(); xint_mtip_i = 1'b0; #1;
    chk("mti_drain_stall", {31'd0, stall_o}, 32'd1);
    cyc();
    chk_trap("mti_trap", 4'd7, 1'b1, 32'h200, 32'd0);
    cyc(); redirect_ready_i = 1'b1; #1;
    chk("mti_rpc", redirect_pc_o, 32'h0000_101C);
    cyc(); redirect_ready_i = 1'b0; #1;
    all_zero("mti_back_idle");

    // Exception and external interrupt together: exception first, interrupt afterwards
    mie_meie_i = 1'b1; mie_msie_i = 1'b1; xint_meip_i = 1'b1;
    exc_valid_i = 1'b1; exc_code_i = 4'd11; exc_pc_i = 32'h300; exc_inst_i = 32'h0000_0073;
    #1;
    chk("both_flush", {31'd0, flush_o}, 32'd1);
    cyc(); exc_valid_i = 1'b0; #1;
    chk("both_irq_ignored_drain", {31'd0, flush_o}, 32'd0);
    cyc();
    chk_trap("both_exc", 4'd11, 1'b0, 32'h300, 32'h0000_0073);
    cyc(); redirect_ready_i = 1'b1; #1;
    chk("both_exc_rpc", redirect_pc_o, 32'h0000_1000);
    cyc(); redirect_ready_i = 1'b0; #1;
    chk("both_irq_deferred_flush", {31'd0, flush_o}, 32'd1);
    chk("both_irq_deferred_stall", {31'd0, stall_o}, 32'd0);
    cyc(); xint_meip_i = 1'b0; #1;
    chk("mei_drain_stall", {31'd0, stall_o}, 32'd1);
    cyc();
    chk_trap("mei_trap", 4'd11, 1'b1, 32'h200, 32'd0);
    cyc(); redirect_ready_i = 1'b1; #1;
    chk("mei_rpc", redirect_pc_o, 32'h0000_102C);
    cyc(); redirect_ready_i = 1'b0; #1;
    all_zero("mei_back_idle");

    // MSI outranks MTI
    xint_msip_i = 1'b1; xint_mtip_i = 1'b1;
    #1;
    chk("msi_flush", {31'd0, flush_o}, 32'd1);
    cyc(); xint_msip_i = 1'b0; xint_mtip_i = 1'b0; #1;
    cyc();
    chk_trap("msi_trap", 4'd3, 1'b1, 32'h200, 32'd0);
    cyc(); redirect_ready_i = 1'b1; #1;
    chk("msi_rpc", redirect_pc_o, 32'h0000_100C);
    cyc(); redirect_ready_i = 1'b0; #1;

    // Global MIE clear masks interrupts
    mstatus_mie_i = 1'b0; xint_meip_i = 1'b1;
    #1;
    chk("mie_off_flush", {31'd0, flush_o}, 32'd0);
    cyc();
    chk("mie_off_stall", {31'd0, stall_o}, 32'd0);
    xint_meip_i = 1'b0;

    // MRET with 3 cycles of drain and 4 cycles of redirect backpressure
    mret_i = 1'b1; mepc_i = 32'h302; pipe_empty_i = 1'b0;
    #1;
    chk("mret_flush", {31'd0, flush_o}, 32'd1);
    cyc(); mret_i = 1'b0; #1;
    chk("mret_drain1", {30'd0, stall_o, inst_xret_o}, 32'd2);
    cyc(); exc_valid_i = 1'b1; exc_code_i = 4'd3; #1;
    chk("mret_drain2_exc_ignored", {30'd0, stall_o, flush_o}, 32'd2);
    cyc(); exc_valid_i = 1'b0; #1;
    chk("mret_drain3", {30'd0, stall_o, inst_xret_o}, 32'd2);
    pipe_empty_i = 1'b1;
    cyc();
    chk("mret_xret", {30'd0, inst_xret_o, trap_valid_o}, 32'd2);
    cyc();
    chk("mret_xret_once", {31'd0, inst_xret_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("mret_hold_vld", {31'd0, redirect_valid_o}, 32'd1);
      chk("mret_hold_pc", redirect_pc_o, 32'h300);
      if (i >= 1) mepc_i = 32'h500;
      cyc();
    end
    redirect_ready_i = 1'b1;
    #1;
    chk("mret_handshake_pc", redirect_pc_o, 32'h300);
    cyc(); redirect_ready_i = 1'b0; #1;
    all_zero("mret_back_idle");

    // Reset while draining discards the exception
    exc_valid_i = 1'b1; exc_code_i = 4'd3; exc_pc_i = 32'h400; pipe_empty_i = 1'b0;
    #1;
    chk("rst_exc_flush", {31'd0, flush_o}, 32'd1);
    cyc(); exc_valid_i = 1'b0; rst_i = 1'b1; #1;
    chk("rst_in_drain_stall", {31'd0, stall_o}, 32'd1);
    cyc(); rst_i = 1'b0; pipe_empty_i = 1'b1; #1;
    all_zero("rst_after");
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_no_trap", {29'd0, trap_valid_o, inst_xret_o, stall_o}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/titan_trap_ctrl.md
TITAN_TRAP_CTRL -- requirements
Module: titan_trap_ctrl

Interface
REQ-001 Parameter VECTORED_EN, default 1, enables vectored interrupt redirect when mtvec_i[1:0]==2'b01.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset; synchronous, active-high.
REQ-004 xint_meip_i, xint_mtip_i, xint_msip_i  in  1 each  raw external/timer/software interrupt pending.
REQ-005 mie_meie_i, mie_mtie_i, mie_msie_i, mstatus_mie_i  in  1 each  enable bits from CSR file.
REQ-006 exc_valid_i  in  1  synchronous exception request; exc_code_i  in  4  cause; exc_pc_i  in  32  faulting PC; exc_inst_i  in  32  faulting instruction.
REQ-007 mret_i  in  1  MRET reached commit; commit_pc_i  in  32  PC of next unretired instruction.
REQ-008 pipe_empty_i  in  1  pipeline drained; mtvec_i, mepc_i  in  32  current CSR values; redirect_ready_i  in  1  fetch accepts redirect.
REQ-009 trap_valid_o  out  1; exception_code_o  out  4; interrupt_code_o  out  1; exception_pc_o  out  32; exception_inst_o  out  32  CSR trap-commit bundle.
REQ-010 inst_xret_o  out  1  MRET commit pulse to CSR file.
REQ-011 flush_o  out  1; stall_o  out  1; redirect_valid_o  out  1; redirect_pc_o  out  32.

Function
REQ-012 FSM states: IDLE, DRAIN, TRAP, XRET, REDIRECT.
REQ-013 IDLE acceptance priority: exc_valid_i > mret_i > interrupt; at most one event accepted per cycle.
REQ-014 Interrupt pending iff mstatus_mie_i and any (pending & enable) pair; cause priority MEI(11) > MSI(3) > MTI(7).
REQ-015 On acceptance: capture cause, interrupt flag, PC (exc_pc_i for exception, commit_pc_i for interrupt), instruction (exc_inst_i for exception, 0 for interrupt), event kind; flush_o=1 for exactly that cycle; next state DRAIN.
REQ-016 stall_o=1 in every state except IDLE.
REQ-017 DRAIN: hold until pipe_empty_i=1; then go to TRAP (exception/interrupt) or XRET (mret).
REQ-018 DRAIN entered with pipe_empty_i already 1 leaves after one cycle.
REQ-019 TRAP: trap_valid_o=1 for exactly one cycle with captured bundle; next REDIRECT.
REQ-020 XRET: inst_xret_o=1 for exactly one cycle; next REDIRECT.
REQ-021 Redirect target: mret -> {mepc_i[31:2],2'b00}; exception, or interrupt with vectoring off -> {mtvec_i[31:2],2'b00}; interrupt with VECTORED_EN=1 and mtvec_i[1:0]==2'b01 -> {mtvec_i[31:2],2'b00} + 4*cause, 32-bit wrap.
REQ-022 Target computed in REDIRECT from CSR values updated by TRAP/XRET; held stable while redirect_valid_o=1.
REQ-023 REDIRECT: redirect_valid_o=1 until redirect_ready_i=1; transfer cycle returns to IDLE.
REQ-024 Events arriving outside IDLE are ignored (not queued); interrupt deasserting after capture is still taken.
REQ-025 Exception and interrupt in same cycle: exception taken, interrupt reconsidered once back in IDLE.
REQ-026 Outputs not explicitly asserted in a state are 0.

Reset
REQ-027 rst_i=1 forces IDLE and clears all captured registers regardless of current state; all outputs 0 in the following cycle.
REQ-028 Reset mid-DRAIN/REDIRECT discards the pending event; no trap_valid_o or inst_xret_o afterwards.

Structure
REQ-029 Cause codes (MEI=11, MSI=3, MTI=7, ILLEGAL_INST=2, BREAKPOINT=3, MCALL=11) and FSM encoding reside in shared package titan_pkg.
REQ-030 Interrupt priority encoder is sub-module titan_irq_prio (inputs pending/enable/mstatus_mie; outputs valid, 4-bit cause).

Verification
REQ-031 exc_valid_i=1, exc_code_i=2, exc_pc_i=0x100, exc_inst_i=0xFFFFFFFF, pipe_empty_i=1 -> flush_o one cycle; trap_valid_o two cycles later with code 2, int 0, pc 0x100; redirect_pc_o=mtvec base.
REQ-032 mstatus_mie_i=1, mie_mtie_i=1, xint_mtip_i=1, mtvec_i=0x1001, commit_pc_i=0x200 -> trap_valid_o with int 1, code 7, pc 0x200; redirect_pc_o=0x101C.
REQ-033 Same cycle exc_valid_i (code 11) and xint_meip_i with all enables set -> exception code 11, int 0; interrupt taken after return to IDLE.
REQ-034 mret_i=1, mepc_i=0x302, pipe_empty_i low 3 cycles -> stall 3 DRAIN cycles, inst_xret_o one pulse, redirect_pc_o=0x300.
REQ-035 redirect_ready_i low 4 cycles -> redirect_valid_o and redirect_pc_o stable 4 cycles, IDLE after handshake.
REQ-036 rst_i asserted in DRAIN -> next cycle IDLE, all outputs 0, no trap_valid_o.
